// File: rtl/params_pkg.sv
// Shared RV64 fetch-path parameters and the IF/ID pipeline register layout.
package params_pkg;

   localparam int INST_WIDTH                = 32;
   localparam int INST_BYTE_WIDTH           = 4;
   localparam int RISC_V_DATA_WIDTH         = 64;
   localparam int INST_MEM_DEPTH            = 64;
   localparam int INST_MEMORY_ADDRESS_WIDTH = 8;

   localparam logic [INST_WIDTH-1:0]        NOP        = 32'h0000_0013;
   localparam logic [RISC_V_DATA_WIDTH-1:0] IMEM_BYTES = 64'(INST_MEM_DEPTH * INST_BYTE_WIDTH);

   typedef struct packed {
      logic [RISC_V_DATA_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0]        inst;
      logic                         valid;
   } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: load has priority over hold, otherwise advances one instruction.
// One-cycle update; hold freezes the value indefinitely.
module pc_reg
   import params_pkg::*;
#(
   parameter logic [RISC_V_DATA_WIDTH-1:0] RESET_PC = 64'h0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic                         hold,
   input  logic [RISC_V_DATA_WIDTH-1:0] load_pc,
   output logic [RISC_V_DATA_WIDTH-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= load_pc;
      end else if (!hold) begin
         pc <= pc + RISC_V_DATA_WIDTH'(INST_BYTE_WIDTH);
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register; optional counters under IF_PERF_COUNTERS_EN.
// One-cycle fetch latency; stall holds PC and IF/ID, redirect overrides stall and halt.
module if_stage
   import params_pkg::*;
#(
   parameter logic [RISC_V_DATA_WIDTH-1:0] RESET_PC = 64'h0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 stall,
   input  logic                                 redirect,
   input  logic [RISC_V_DATA_WIDTH-1:0]         redirect_pc,
   output logic [INST_MEMORY_ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [INST_WIDTH-1:0]                imem_rdata,
   output logic [RISC_V_DATA_WIDTH-1:0]         if_id_pc,
   output logic [INST_WIDTH-1:0]                if_id_inst,
   output logic                                 if_id_valid,
   output logic                                 halted
`ifdef IF_PERF_COUNTERS_EN
   ,
   output logic [31:0]                          fetch_count,
   output logic [31:0]                          stall_count
`endif
);

   logic [RISC_V_DATA_WIDTH-1:0] pc;
   logic [RISC_V_DATA_WIDTH-1:0] target_pc;
   logic                         fetch_en;
   logic                         stall_en;
   logic                         unused_align;
   if_id_t                       if_id_q;

   // Targets are forced to instruction alignment; the low bits are dropped.
   assign target_pc    = {redirect_pc[RISC_V_DATA_WIDTH-1:2], 2'b00};
   assign unused_align = ^redirect_pc[1:0];

   assign halted    = (pc >= IMEM_BYTES);
   assign imem_addr = pc[INST_MEMORY_ADDRESS_WIDTH-1:0];
   assign fetch_en  = !redirect && !halted && !stall;
   assign stall_en  = !redirect && !halted && stall;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (redirect),
      .hold    (halted || stall),
      .load_pc (target_pc),
      .pc      (pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_id_q <= '{pc: '0, inst: NOP, valid: 1'b0};
      end else if (redirect || halted) begin
         if_id_q <= '{pc: pc, inst: NOP, valid: 1'b0};
      end else if (!stall) begin
         if_id_q <= '{pc: pc, inst: imem_rdata, valid: 1'b1};
      end
   end

   assign if_id_pc    = if_id_q.pc;
   assign if_id_inst  = if_id_q.inst;
   assign if_id_valid = if_id_q.valid;

`ifdef IF_PERF_COUNTERS_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (fetch_en && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
         if (stall_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt;
   assign stall_count = stall_cnt;
`else
   logic unused_perf;
   assign unused_perf = fetch_en ^ stall_en;
`endif

endmodule
